// File: rtl/io_serializer.sv
// io_serializer
//   Takes parallel words over a valid/ready handshake and shifts each one out
//   on the io_data / io_enable pin pair at CLK_DIV clocks per bit. After each
//   frame it holds the line idle for GAP_CYCLES clocks, then spends one IDLE
//   cycle before it can accept the next word. It counts completed frames.
//
// Ports
//   clk          rd_clk domain clock
//   reset        synchronous, active-high
//   in_data      word to serialize
//   in_valid     in_data valid
//   in_ready     block can accept a word this cycle
//   io_data      serial data, idles high
//   io_enable    high for every bit of a frame
//   busy         state != IDLE
//   frame_done   single-cycle pulse in the first cycle after the last bit
//   frame_count  completed frames, wraps
module io_serializer #(
    parameter int DATA_WIDTH  = 16,
    parameter int CLK_DIV     = 4,
    parameter int GAP_CYCLES  = 2,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   io_data,
    output logic                   io_enable,
    output logic                   busy,
    output logic                   frame_done,
    output logic [COUNT_WIDTH-1:0] frame_count
);

    // Reject unusable configurations at elaboration.
    if (DATA_WIDTH < 2) begin : g_bad_data_width
        $fatal(1, "io_serializer: DATA_WIDTH must be >= 2");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $fatal(1, "io_serializer: CLK_DIV must be >= 1");
    end
    if (GAP_CYCLES < 0) begin : g_bad_gap
        $fatal(1, "io_serializer: GAP_CYCLES must be >= 0");
    end
    if (COUNT_WIDTH < 1) begin : g_bad_count_width
        $fatal(1, "io_serializer: COUNT_WIDTH must be >= 1");
    end

    // Counter widths are clamped to at least one bit so degenerate settings
    // (CLK_DIV=1, GAP_CYCLES<=1) still give legal declarations.
    localparam int DIV_W = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   sreg, sreg_nxt, sreg_adv;
    logic [DIV_W-1:0]        div_cnt, div_nxt;
    logic [BIT_W-1:0]        bit_cnt, bit_nxt;
    logic [GAP_W-1:0]        gap_cnt, gap_nxt;
    logic                    io_data_nxt;
    logic                    io_enable_nxt;
    logic                    frame_done_nxt;
    logic [COUNT_WIDTH-1:0]  count_nxt;
    logic                    accept;

    // The bit currently on the wire always sits at the outgoing end of the
    // shift register, so io_data is just that end of the register.
    function automatic logic out_bit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    assign in_ready = (state == IDLE) && !reset;
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign sreg_adv = MSB_FIRST ? (sreg << 1) : (sreg >> 1);

    // Next-state and next-output logic. Every pin output is registered, so
    // this block computes what the pins show in the following cycle.
    always_comb begin
        state_nxt      = state;
        sreg_nxt       = sreg;
        div_nxt        = div_cnt;
        bit_nxt        = bit_cnt;
        gap_nxt        = gap_cnt;
        io_data_nxt    = 1'b1;
        io_enable_nxt  = 1'b0;
        frame_done_nxt = 1'b0;
        count_nxt      = frame_count;

        case (state)
            IDLE: begin
                if (accept) begin
                    // First bit goes on the wire in the cycle after the accept.
                    state_nxt     = SHIFT;
                    sreg_nxt      = in_data;
                    div_nxt       = '0;
                    bit_nxt       = '0;
                    io_enable_nxt = 1'b1;
                    io_data_nxt   = out_bit(in_data);
                end
            end

            SHIFT: begin
                io_enable_nxt = 1'b1;
                io_data_nxt   = io_data;
                if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        // Last bit has had its full CLK_DIV clocks: the line
                        // drops to idle and the frame is credited together.
                        io_enable_nxt  = 1'b0;
                        io_data_nxt    = 1'b1;
                        frame_done_nxt = 1'b1;
                        count_nxt      = frame_count + 1'b1;
                        bit_nxt        = '0;
                        gap_nxt        = '0;
                        state_nxt      = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        bit_nxt     = bit_cnt + 1'b1;
                        sreg_nxt    = sreg_adv;
                        io_data_nxt = out_bit(sreg_adv);
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A reset mid-frame simply wipes everything: the partial word is lost
    // and the frame is neither pulsed nor counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sreg        <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            io_data     <= 1'b1;
            io_enable   <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_nxt;
            sreg        <= sreg_nxt;
            div_cnt     <= div_nxt;
            bit_cnt     <= bit_nxt;
            gap_cnt     <= gap_nxt;
            io_data     <= io_data_nxt;
            io_enable   <= io_enable_nxt;
            frame_done  <= frame_done_nxt;
            frame_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_io_serializer.sv
// Bench for io_serializer. Three instances with different parameter sets:
//   0: defaults (16 bit, CLK_DIV 4, GAP 2, MSB first)
//   1: MSB_FIRST=0, CLK_DIV=1, GAP_CYCLES=0
//   2: COUNT_WIDTH=4, CLK_DIV=1, GAP_CYCLES=0
// Stimulus pushes the expected serial pattern of each frame into a queue; a
// monitor rebuilds every frame seen on the pins and checks it against the
// queue head when io_enable drops.
module tb_io_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]       rst_v;
    logic [2:0]       vld_v;
    logic [2:0][15:0] dat_v;
    logic [2:0]       rdy_v, iod_v, ioe_v, busy_v, fd_v;
    logic [15:0]      fc0, fc1;
    logic [3:0]       fc2;
    logic [2:0][15:0] fc_v;

    assign fc_v[0] = fc0;
    assign fc_v[1] = fc1;
    assign fc_v[2] = {12'b0, fc2};

    io_serializer u_dut0 (
        .clk(clk), .reset(rst_v[0]), .in_data(dat_v[0]), .in_valid(vld_v[0]),
        .in_ready(rdy_v[0]), .io_data(iod_v[0]), .io_enable(ioe_v[0]),
        .busy(busy_v[0]), .frame_done(fd_v[0]), .frame_count(fc0)
    );

    io_serializer #(.MSB_FIRST(1'b0), .CLK_DIV(1), .GAP_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(rst_v[1]), .in_data(dat_v[1]), .in_valid(vld_v[1]),
        .in_ready(rdy_v[1]), .io_data(iod_v[1]), .io_enable(ioe_v[1]),
        .busy(busy_v[1]), .frame_done(fd_v[1]), .frame_count(fc1)
    );

    io_serializer #(.COUNT_WIDTH(4), .CLK_DIV(1), .GAP_CYCLES(0)) u_dut2 (
        .clk(clk), .reset(rst_v[2]), .in_data(dat_v[2]), .in_valid(vld_v[2]),
        .in_ready(rdy_v[2]), .io_data(iod_v[2]), .io_enable(ioe_v[2]),
        .busy(busy_v[2]), .frame_done(fd_v[2]), .frame_count(fc2)
    );

    // seq holds the serial bits in wire order, first bit at [15].
    typedef struct {
        int          dut;
        logic [15:0] seq;
        bit          abort;
        int          cnt;
        int          rise;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_cnt[3] = '{0, 0, 0};

    function automatic int cdiv(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int cmod(input int d);
        return (d == 2) ? 16 : 65536;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    bit          in_frame[3] = '{0, 0, 0};
    int          len[3];
    int          rise[3];
    logic [15:0] seq[3];
    bit          held_ok[3];
    logic        last[3];
    int          fd_cnt[3] = '{0, 0, 0};

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (fd_v[d] === 1'b1) fd_cnt[d]++;
            if (ioe_v[d] === 1'b1) begin
                if (!in_frame[d]) begin
                    in_frame[d] = 1'b1;
                    len[d]      = 0;
                    rise[d]     = cyc;
                    seq[d]      = '0;
                    held_ok[d]  = 1'b1;
                end
                if (len[d] % cdiv(d) == 0) seq[d] = {seq[d][14:0], iod_v[d]};
                else if (iod_v[d] !== last[d]) held_ok[d] = 1'b0;
                last[d] = iod_v[d];
                len[d]++;
            end else if (in_frame[d]) begin
                in_frame[d] = 1'b0;
                if (q.size() == 0) begin
                    chk("unexpected_frame", d, -1);
                end else begin
                    e = q.pop_front();
                    chk("frame_dut", d, e.dut);
                    chk("enable_rise_cycle", rise[d], e.rise);
                    chk("idle_io_data", iod_v[d], 1);
                    chk("frame_done_at_end", fd_v[d], e.abort ? 0 : 1);
                    chk("frame_count", fc_v[d], e.cnt);
                    if (!e.abort) begin
                        chk("enable_length", len[d], 16 * cdiv(d));
                        chk("serial_bits", seq[d], e.seq);
                        chk("bit_held_clk_div", held_ok[d], 1);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge. Presents w, waits for in_ready, and returns at the
    // negedge after the accepting edge with acc = cycle number of that cycle.
    task automatic send(input int d, input logic [15:0] w, input logic [15:0] s,
                        input bit ab, output int acc);
        exp_t e;
        int   t;
        dat_v[d] = w;
        vld_v[d] = 1'b1;
        t = 0;
        while (rdy_v[d] !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (rdy_v[d] !== 1'b1) begin
            chk("send_timeout", 0, 1);
            acc = -1;
            return;
        end
        acc    = cyc + 1;
        e.dut  = d;
        e.seq  = s;
        e.abort = ab;
        e.rise = acc;
        if (!ab) begin
            model_cnt[d] = (model_cnt[d] + 1) % cmod(d);
            e.cnt = model_cnt[d];
        end else begin
            e.cnt = 0;
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wait_done();
        int t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int a1, a2, c0, t;
        logic [15:0] w;
        rst_v = 3'b111;
        vld_v = '0;
        dat_v = '0;

        // Reset hold of three cycles.
        repeat (3) begin
            @(negedge clk);
            chk("rst_io_data", iod_v[0], 1);
            chk("rst_io_enable", ioe_v[0], 0);
            chk("rst_in_ready", rdy_v[0], 0);
            chk("rst_frame_count", fc_v[0], 0);
            chk("rst_busy", busy_v[0], 0);
        end
        rst_v = 3'b000;
        #1;
        chk("ready_after_release", rdy_v[0], 1);
        @(negedge clk);

        // Single frame 0xA5C3 with defaults.
        send(0, 16'hA5C3, 16'hA5C3, 1'b0, a1);
        vld_v[0] = 1'b0;
        t = 0;
        while (rdy_v[0] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready_again_cycle", cyc - a1, 66);
        wait_done();
        chk("count_after_first", fc_v[0], 1);

        // in_valid held continuously across two words.
        send(0, 16'h0001, 16'h0001, 1'b0, a1);
        send(0, 16'h8000, 16'h8000, 1'b0, a2);
        vld_v[0] = 1'b0;
        chk("accept_spacing_default", a2 - a1, 67);
        wait_done();

        // LSB first, one clock per bit, no gap.
        send(1, 16'h0003, 16'hC000, 1'b0, a1);
        send(1, 16'h00F0, 16'h0F00, 1'b0, a2);
        vld_v[1] = 1'b0;
        chk("accept_spacing_div1", a2 - a1, 17);
        wait_done();

        // Reset at the start of bit 7 of a 0xFFFF frame.
        send(0, 16'hFFFF, 16'hFFFF, 1'b1, a1);
        vld_v[0] = 1'b0;
        repeat (28) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        model_cnt[0] = 0;
        #1;
        chk("abort_io_enable", ioe_v[0], 0);
        chk("abort_io_data", iod_v[0], 1);
        chk("abort_frame_done", fd_v[0], 0);
        chk("abort_in_ready", rdy_v[0], 1);
        c0 = cyc;
        send(0, 16'h1234, 16'h1234, 1'b0, a2);
        vld_v[0] = 1'b0;
        chk("accept_after_reset", a2, c0 + 1);
        wait_done();
        chk("count_after_abort", fc_v[0], 1);

        // 17 back-to-back frames on the 4-bit counter instance.
        a1 = 0;
        for (int i = 0; i < 17; i++) begin
            w = 16'(i * 16'h1111) ^ 16'h5A0F;
            send(2, w, w, 1'b0, a2);
            if (i > 0) chk("accept_spacing_b2b", a2 - a1, 17);
            a1 = a2;
        end
        vld_v[2] = 1'b0;
        wait_done();
        chk("count_wrapped", fc_v[2], 1);
        chk("pulses_dut2", fd_cnt[2], 17);
        chk("pulses_dut1", fd_cnt[1], 2);
        chk("pulses_dut0", fd_cnt[0], 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/io_serializer.md
Name: io_serializer

Overview:
- Downstream of data_sink, in the rd_clk domain; replaces the dummy bus_controller.
- Accepts parallel words over a valid/ready handshake and shifts each one out on the io_data/io_enable pin pair at a programmable bit rate.
- Inserts an idle gap between frames.
- Counts completed frames for debug visibility.

Parameters:
- DATA_WIDTH, 16, width of each parallel word; must be >= 2.
- CLK_DIV, 4, clocks per serial bit; must be >= 1.
- GAP_CYCLES, 2, idle clocks after each frame; 0 is legal.
- MSB_FIRST, 1, 1 = shift out bit DATA_WIDTH-1 first, 0 = bit 0 first.
- COUNT_WIDTH, 16, width of frame_count.

Ports:
- clk  in  1  rd_clk domain clock
- reset  in  1  synchronous, active-high
- in_data  in  DATA_WIDTH  word to serialize
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a word this cycle
- io_data  out  1  serial data; idles high
- io_enable  out  1  high for every bit of a frame
- busy  out  1  state != IDLE
- frame_done  out  1  single-cycle pulse at frame end
- frame_count  out  COUNT_WIDTH  completed frames, wraps

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: io_data=1, io_enable=0, frame_done=0, frame_count=0, busy=0, state=IDLE, all internal counters 0.
- in_ready = (state==IDLE) && !reset; it is combinational from registered state.
- Transfer occurs on a rising edge with in_valid && in_ready. in_data is captured into the shift register and the block moves to SHIFT.
- in_valid while in_ready=0 is ignored. There is no buffering; upstream holds the word.
- io_data, io_enable and frame_done are all registered.
- States:
  - IDLE: io_enable=0, io_data=1. On transfer, go to SHIFT.
  - SHIFT:
    - io_enable=1; io_data = current bit, chosen per MSB_FIRST.
    - div_cnt counts 0..CLK_DIV-1. On wrap, bit_cnt increments and the shift register advances.
    - After bit_cnt = DATA_WIDTH-1 completes its CLK_DIV clocks: go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP: io_enable=0, io_data=1 for GAP_CYCLES clocks, then IDLE.
- Frame timing:
  - The first data bit appears on io_data in the cycle after the accepting edge (latency 1).
  - io_enable stays high for exactly DATA_WIDTH*CLK_DIV consecutive cycles.
- frame_done pulses in the first cycle after the last bit (io_enable already 0). frame_count increments on that same edge and wraps from 2^COUNT_WIDTH-1 to 0.
- Max throughput: one word per DATA_WIDTH*CLK_DIV + GAP_CYCLES + 1 cycles. The block always spends at least one IDLE cycle between frames.
- Reset mid-frame:
  - The next cycle shows reset values.
  - The frame is aborted: no frame_done, not counted, and the partial word is discarded.
- Reset asserted in the same cycle as in_valid: there is no transfer, because in_ready=0.
- CLK_DIV=1: io_data changes every cycle, and io_enable is high for exactly DATA_WIDTH cycles.
- Elaboration must fail if DATA_WIDTH<2 or CLK_DIV<1.

Test Plan:
- Reset hold of 3 cycles, then release:
  - During reset: io_data=1, io_enable=0, in_ready=0, frame_count=0.
  - First cycle after release: in_ready=1.
- Defaults, accept 0xA5C3 at edge t0:
  - io_enable high in cycles t0+1..t0+64.
  - io_data = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, each bit held 4 cycles.
  - frame_done pulse in cycle t0+65; frame_count=1.
  - in_ready=1 again in cycle t0+67.
- Defaults, in_valid held continuously with 0x0001 then 0x8000:
  - The two accepts are exactly 67 cycles apart.
  - Frame 1 io_data is 0 for 60 cycles, then 1 for 4.
  - Frame 2 io_data is 1 for 4 cycles, then 0 for 60.
- MSB_FIRST=0, CLK_DIV=1, GAP_CYCLES=0, send 0x0003:
  - io_data = 1,1 followed by 14 zeros, one cycle per bit.
  - io_enable high for 16 cycles; next accept possible 17 cycles after the first.
- Defaults, reset asserted at the start of bit 7 of frame 0xFFFF:
  - Next cycle: io_enable=0, io_data=1.
  - No frame_done pulse; frame_count stays 0.
  - A new word is accepted on the first post-reset cycle.
- COUNT_WIDTH=4, CLK_DIV=1, GAP_CYCLES=0, 17 frames back-to-back:
  - frame_count reads 15 after frame 15, 0 after frame 16, 1 after frame 17.
  - 17 frame_done pulses in total.
